// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Round-robin arbiter that merges I-side and D-side line
//               requests onto one downstream port, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [s_line-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [s_line-1:0] d_wdata,
    output logic [s_line-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_address,
    output logic [s_line-1:0] mem_wdata,
    input  logic [s_line-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_grant_i = 2'd1;
    localparam logic [1:0] c_grant_d = 2'd2;
    localparam logic       c_port_i  = 1'b0;
    localparam logic       c_port_d  = 1'b1;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_last_grant;
    logic [31:0]       r_addr;
    logic [s_line-1:0] r_wdata;
    logic              r_op_write;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;

    assign w_i_req   = i_read;
    assign w_d_req   = d_read | d_write;
    // On a tie, the port that was not served last wins.
    assign w_grant_d = w_d_req & (~w_i_req | (r_last_grant == c_port_i));
    assign w_grant_i = w_i_req & ~w_grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_idle;
            r_last_grant <= c_port_i;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_op_write   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_idle: begin
                    if (w_grant_d) begin
                        r_addr     <= d_address;
                        r_wdata    <= d_wdata;
                        r_op_write <= d_write;
                    end else if (w_grant_i) begin
                        r_addr     <= i_address;
                        r_op_write <= 1'b0;
                    end
                end
                c_grant_i: if (mem_resp) r_last_grant <= c_port_i;
                c_grant_d: if (mem_resp) r_last_grant <= c_port_d;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_grant_d)      w_next_state = c_grant_d;
                else if (w_grant_i) w_next_state = c_grant_i;
            end
            c_grant_i: if (mem_resp) w_next_state = c_idle;
            c_grant_d: if (mem_resp) w_next_state = c_idle;
            default:   w_next_state = c_idle;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (r_state)
            c_grant_i: begin
                mem_read  = ~r_op_write;
                mem_write = r_op_write;
                i_resp    = mem_resp;
            end
            c_grant_d: begin
                mem_read  = ~r_op_write;
                mem_write = r_op_write;
                d_resp    = mem_resp;
            end
            default: ;
        endcase
    end

    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Directed scoreboard bench for cache_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

    logic         clk;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    cache_arbiter #(.s_line(256)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    typedef struct { bit wr; logic [31:0] addr; logic [255:0] wdata; } cmd_t;
    typedef struct { bit is_d; logic [255:0] data; } rsp_t;

    cmd_t        cmd_q[$];
    rsp_t        rsp_q[$];
    int          total = 0;
    int          bad   = 0;
    bit          auto_en = 1;
    int          resp_delay = 3;
    int          cnt = 0;
    bit          prev_cmd = 0;
    logic [31:0] cur_addr = '0;
    cmd_t        cc;
    rsp_t        rr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] data_for(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_cmd(input bit wr, input logic [31:0] a, input logic [255:0] w);
        cmd_t c;
        c.wr = wr; c.addr = a; c.wdata = w;
        cmd_q.push_back(c);
    endtask

    task automatic push_rsp(input bit is_d, input logic [31:0] a);
        rsp_t r;
        r.is_d = is_d; r.data = data_for(a);
        rsp_q.push_back(r);
    endtask

    // Returns cycles waited, or -1 if no response arrived within the budget.
    task automatic wait_resp(input bit want_i, input bit want_d, output int n);
        n = -1;
        for (int k = 0; k < 40; k++) begin
            if ((want_i && i_resp) || (want_d && d_resp)) begin
                n = k;
                return;
            end
            tick();
        end
    endtask

    // Downstream memory model: answers after resp_delay command cycles.
    initial begin
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp = 1'b0;
            if (auto_en && (mem_read || mem_write) && !rst) begin
                cnt++;
                if (cnt == resp_delay) begin
                    mem_resp  = 1'b1;
                    mem_rdata = data_for(mem_address);
                    cnt       = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard: commands and upstream responses compared as the DUT emits them.
    always @(negedge clk) begin
        if (mem_read || mem_write) begin
            if (!prev_cmd) begin
                total++;
                assert (cmd_q.size() != 0) else begin
                    bad++;
                    $error("FAIL cmd_unexpected observed=%0h expected=none", mem_address);
                end
                if (cmd_q.size() != 0) begin
                    cc = cmd_q.pop_front();
                    cur_addr = cc.addr;
                    check("cmd_op", 256'({mem_write, mem_read}), 256'({cc.wr, !cc.wr}));
                    check("cmd_addr", 256'(mem_address), 256'(cc.addr));
                    if (cc.wr) check("cmd_wdata", mem_wdata, cc.wdata);
                end
            end
            check("addr_stable", 256'(mem_address), 256'(cur_addr));
        end
        prev_cmd = mem_read || mem_write;
        if (i_resp || d_resp) begin
            total++;
            assert (rsp_q.size() != 0) else begin
                bad++;
                $error("FAIL resp_unexpected observed=%0d%0d expected=00", i_resp, d_resp);
            end
            if (rsp_q.size() != 0) begin
                rr = rsp_q.pop_front();
                check("resp_port", 256'({d_resp, i_resp}), 256'({rr.is_d, !rr.is_d}));
                check("resp_data", rr.is_d ? d_rdata : i_rdata, rr.data);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_mem_read", 256'(mem_read), 256'(0));
        check("rst_mem_write", 256'(mem_write), 256'(0));
        check("rst_resps", 256'({i_resp, d_resp}), 256'(0));
        check("rst_mem_addr", 256'(mem_address), 256'(0));

        // Single I-side read with exact latency
        i_read = 1'b1; i_address = 32'h0000_1000;
        push_cmd(1'b0, 32'h1000, '0); push_rsp(1'b0, 32'h1000);
        tick();
        check("i_cmd_latency", 256'(mem_read), 256'(1));
        wait_resp(1'b1, 1'b0, n);
        check("i_resp_latency", 256'(n), 256'(2));
        check("i_only_dresp", 256'(d_resp), 256'(0));
        i_read = 1'b0;
        tick();
        check("turnaround_idle", 256'({mem_read, mem_write}), 256'(0));

        // Simultaneous I read and D write right after reset: D first
        rst = 1'b1; tick(); rst = 1'b0;
        i_read = 1'b1; i_address = 32'h0000_1100;
        d_write = 1'b1; d_address = 32'h0000_2000; d_wdata = {32{8'hA5}};
        push_cmd(1'b1, 32'h2000, {32{8'hA5}}); push_cmd(1'b0, 32'h1100, '0);
        push_rsp(1'b1, 32'h2000); push_rsp(1'b0, 32'h1100);
        wait_resp(1'b0, 1'b1, n);
        check("tie_d_done", 256'(n >= 0), 256'(1));
        d_write = 1'b0;
        tick();
        check("tie_idle_gap", 256'({mem_read, mem_write}), 256'(0));
        tick();
        check("tie_i_next", 256'(mem_read), 256'(1));
        wait_resp(1'b1, 1'b0, n);
        check("tie_i_done", 256'(n >= 0), 256'(1));
        i_read = 1'b0;
        tick();

        // Both ports held for six transactions: strict alternation
        rst = 1'b1; tick(); rst = 1'b0;
        i_read = 1'b1; i_address = 32'h0000_6000;
        d_write = 1'b1; d_address = 32'h0000_5000; d_wdata = {32{8'h5C}};
        for (int k = 0; k < 3; k++) begin
            push_cmd(1'b1, 32'h5000, {32{8'h5C}}); push_cmd(1'b0, 32'h6000, '0);
            push_rsp(1'b1, 32'h5000); push_rsp(1'b0, 32'h6000);
        end
        for (int k = 0; k < 6; k++) begin
            wait_resp(1'b1, 1'b1, n);
            check("rr_progress", 256'(n >= 0), 256'(1));
            if (k < 5) tick();
        end
        i_read = 1'b0; d_write = 1'b0;
        tick();

        // Read and write together on D: write only
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_7000; d_wdata = {32{8'h3C}};
        push_cmd(1'b1, 32'h7000, {32{8'h3C}}); push_rsp(1'b1, 32'h7000);
        tick();
        check("rw_no_read", 256'({mem_read, mem_write}), 256'(1));
        wait_resp(1'b0, 1'b1, n);
        check("rw_done", 256'(n >= 0), 256'(1));
        d_read = 1'b0; d_write = 1'b0;
        tick();

        // Reset during a D write grant, then a stray mem_resp
        resp_delay = 10;
        d_write = 1'b1; d_address = 32'h0000_8000; d_wdata = {32{8'h77}};
        push_cmd(1'b1, 32'h8000, {32{8'h77}});
        tick();
        check("abort_cmd_on", 256'(mem_write), 256'(1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; d_write = 1'b0;
        check("abort_cmd_off", 256'({mem_read, mem_write}), 256'(0));
        auto_en = 1'b0;
        mem_resp = 1'b1;
        #1;
        check("stray_resp", 256'({i_resp, d_resp}), 256'(0));
        tick();
        check("stray_no_cmd", 256'({mem_read, mem_write}), 256'(0));
        auto_en = 1'b1; resp_delay = 4;

        // Address change during own grant is ignored
        i_read = 1'b1; i_address = 32'h0000_3000;
        push_cmd(1'b0, 32'h3000, '0); push_rsp(1'b0, 32'h3000);
        tick(); tick();
        i_address = 32'h0000_4000;
        wait_resp(1'b1, 1'b0, n);
        check("addr_chg_done", 256'(n >= 0), 256'(1));
        check("addr_chg_hold", 256'(mem_address), 256'(32'h3000));
        i_read = 1'b0;
        tick();

        // Request dropped mid-grant still completes
        i_read = 1'b1; i_address = 32'h0000_9000;
        push_cmd(1'b0, 32'h9000, '0); push_rsp(1'b0, 32'h9000);
        tick();
        i_read = 1'b0;
        wait_resp(1'b1, 1'b0, n);
        check("drop_still_resp", 256'(n >= 0), 256'(1));
        tick(); tick();

        check("cmd_q_empty", 256'(cmd_q.size()), 256'(0));
        check("rsp_q_empty", 256'(rsp_q.size()), 256'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
